// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: fetch, write-back and ID/EX signals of the decode stage
interface decode_stage_pipe_if #(parameter int WIDTH = 16, parameter int AW = 3);
  logic in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic reg_wr, alu_src, mem_rd, mem_wr;
  logic [4:0] alu_op;
  logic [WIDTH-1:0] instr, wb_data, op1, op2, imm;
  logic [AW-1:0] wb_addr, rd_addr;
  modport master (
    output in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
    input in_ready, out_valid, alu_op, reg_wr, alu_src, mem_rd, mem_wr, op1, op2, imm, rd_addr
  );
  modport slave (
    input in_valid, instr, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, alu_op, reg_wr, alu_src, mem_rd, mem_wr, op1, op2, imm, rd_addr
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: register-file decode stage with two-word immediates, bypass, load-use interlock and ID/EX register
module decode_stage_pipe #(
  parameter int WIDTH = 16,
  parameter int REG_COUNT = 8,
  localparam int AW = $clog2(REG_COUNT)
) (
  input logic clk,
  input logic rst,
  decode_stage_pipe_if.slave bus
);
  typedef enum logic {IDLE, WAIT_IMM} state_t;
  state_t state;
  logic [WIDTH-1:0] regs [REG_COUNT];
  logic [4:0] op, l_op, f_op;
  logic [AW-1:0] rs1, rs2, rd, l_rs1, l_rs2, l_rd, f_rd;
  logic [WIDTH-1:0] rd1, rd2, l_op1, l_op2, b_op1, b_op2, f_op1, f_op2;
  logic adv, stall, acc, two_word, wait_imm;
  function automatic logic [3:0] ctrl(input logic [4:0] o);
    return o == 5'd0 ? 4'b0000 : o[4:3] == 2'b00 ? 4'b1000 : o[4:3] == 2'b01 ? 4'b1100 :
           o[4:3] == 2'b10 ? 4'b1110 : 4'b0101;
  endfunction
  assign op = bus.instr[WIDTH-1 -: 5];
  assign rs1 = bus.instr[WIDTH-6 -: AW];
  assign rs2 = bus.instr[WIDTH-6-AW -: AW];
  assign rd = bus.instr[WIDTH-6-2*AW -: AW];
  assign two_word = |op[4:3];
  assign wait_imm = state == WAIT_IMM;
  assign rd1 = (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : regs[rs1];
  assign rd2 = (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : regs[rs2];
  // latched operands track write-backs while waiting for the immediate
  assign b_op1 = (bus.wb_en && bus.wb_addr == l_rs1) ? bus.wb_data : l_op1;
  assign b_op2 = (bus.wb_en && bus.wb_addr == l_rs2) ? bus.wb_data : l_op2;
  assign f_op = wait_imm ? l_op : op;
  assign f_rd = wait_imm ? l_rd : rd;
  assign f_op1 = wait_imm ? b_op1 : rd1;
  assign f_op2 = wait_imm ? b_op2 : rd2;
  assign adv = !bus.out_valid || bus.out_ready;
  assign stall = !wait_imm && bus.out_valid && bus.mem_rd && (bus.rd_addr == rs1 || bus.rd_addr == rs2);
  assign bus.in_ready = !bus.flush && adv && !stall;
  assign acc = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.out_valid <= 1'b0;
      bus.alu_op <= '0;
      {bus.reg_wr, bus.alu_src, bus.mem_rd, bus.mem_wr} <= '0;
      bus.op1 <= '0;
      bus.op2 <= '0;
      bus.imm <= '0;
      bus.rd_addr <= '0;
      l_op <= '0;
      l_rs1 <= '0;
      l_rs2 <= '0;
      l_rd <= '0;
      l_op1 <= '0;
      l_op2 <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (bus.wb_en) regs[bus.wb_addr] <= bus.wb_data;
      if (bus.flush) begin
        state <= IDLE;
        bus.out_valid <= 1'b0;
      end else begin
        if (wait_imm) begin
          l_op1 <= b_op1;
          l_op2 <= b_op2;
        end
        if (adv) bus.out_valid <= 1'b0;
        if (acc && !wait_imm && two_word) begin
          state <= WAIT_IMM;
          l_op <= op;
          l_rs1 <= rs1;
          l_rs2 <= rs2;
          l_rd <= rd;
          l_op1 <= rd1;
          l_op2 <= rd2;
        end
        if (acc && (wait_imm || !two_word)) begin
          state <= IDLE;
          bus.out_valid <= 1'b1;
          bus.alu_op <= f_op;
          {bus.reg_wr, bus.alu_src, bus.mem_rd, bus.mem_wr} <= ctrl(f_op);
          bus.op1 <= f_op1;
          bus.op2 <= f_op2;
          bus.imm <= wait_imm ? bus.instr : '0;
          bus.rd_addr <= f_rd;
        end
      end
    end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: randomized scoreboard bench for decode_stage_pipe against a transaction-level model
module tb_decode_stage_pipe;
  typedef struct {
    logic [4:0] op;
    logic [2:0] rd;
    logic [15:0] a, b, imm;
  } item_t;
  logic clk = 0, rst = 1;
  int nchk = 0, nerr = 0;
  item_t q[$];
  logic [15:0] mreg [8];
  logic pend = 0;
  logic [15:0] pw;
  decode_stage_pipe_if #(.WIDTH(16), .AW(3)) ifc();
  decode_stage_pipe #(.WIDTH(16), .REG_COUNT(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // expected control bits {reg_wr, alu_src, mem_rd, mem_wr} straight from the opcode class table
  function automatic logic [3:0] ctl(input logic [4:0] op);
    logic [3:0] c;
    if (op == 5'd0) return 4'b0000;
    case (op[4:3])
      2'd0: c = 4'b1000;
      2'd1: c = 4'b1100;
      2'd2: c = 4'b1110;
      default: c = 4'b0101;
    endcase
    return c;
  endfunction
  function automatic logic [15:0] rdb(input logic [2:0] r);
    return (ifc.wb_en && ifc.wb_addr == r) ? ifc.wb_data : mreg[r];
  endfunction
  function automatic logic [15:0] word(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
    return {op, a, b, d, 2'b00};
  endfunction
  // one clock cycle of stimulus; the model decides acceptance and what enters ID/EX
  task automatic cyc(input logic iv, input logic [15:0] w, input logic fl, input logic we,
                     input logic [2:0] wa, input logic [15:0] wd, input logic ordy);
    logic stl, exp_rdy, acc, prod;
    item_t it;
    @(negedge clk);
    ifc.in_valid = iv;
    ifc.instr = w;
    ifc.flush = fl;
    ifc.wb_en = we;
    ifc.wb_addr = wa;
    ifc.wb_data = wd;
    ifc.out_ready = ordy;
    #1;
    stl = !pend && q.size() != 0 && q[0].op[4:3] == 2'b10 && (q[0].rd == w[10:8] || q[0].rd == w[7:5]);
    exp_rdy = !fl && (q.size() == 0 || ordy) && !stl;
    chk("in_ready", 64'(ifc.in_ready), 64'(exp_rdy));
    acc = iv && exp_rdy;
    prod = 0;
    it = '{op: 5'd0, rd: 3'd0, a: 16'd0, b: 16'd0, imm: 16'd0};
    if (acc && pend) begin
      it = '{op: pw[15:11], rd: pw[4:2], a: rdb(pw[10:8]), b: rdb(pw[7:5]), imm: w};
      prod = 1;
    end else if (acc && w[15:14] == 2'b00) begin
      it = '{op: w[15:11], rd: w[4:2], a: rdb(w[10:8]), b: rdb(w[7:5]), imm: 16'd0};
      prod = 1;
    end
    @(posedge clk);
    if (we) mreg[wa] = wd;
    if (fl) begin
      q.delete();
      pend = 0;
    end else if (prod) begin
      q.push_back(it);
      pend = 0;
    end else if (acc) begin
      pend = 1;
      pw = w;
    end
  endtask
  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 3'd0, 16'h0, ordy);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    ifc.in_valid = 0;
    ifc.flush = 0;
    ifc.wb_en = 0;
    ifc.out_ready = 0;
    q.delete();
    pend = 0;
    foreach (mreg[i]) mreg[i] = 16'h0;
    @(negedge clk);
    rst = 0;
    #3;
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_fields", {ifc.alu_op, ifc.reg_wr, ifc.alu_src, ifc.mem_rd, ifc.mem_wr, ifc.rd_addr, ifc.op1, ifc.op2, ifc.imm}, 64'd0);
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("out_valid", 64'(ifc.out_valid), 64'(q.size() != 0));
      if (ifc.out_valid && q.size() != 0) begin
        chk("id_ex", {ifc.alu_op, ifc.reg_wr, ifc.alu_src, ifc.mem_rd, ifc.mem_wr, ifc.rd_addr, ifc.op1, ifc.op2, ifc.imm},
            {q[0].op, ctl(q[0].op), q[0].rd, q[0].a, q[0].b, q[0].imm});
        if (ifc.out_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    ifc.in_valid = 0;
    ifc.instr = 0;
    ifc.flush = 0;
    ifc.wb_en = 0;
    ifc.wb_addr = 0;
    ifc.wb_data = 0;
    ifc.out_ready = 0;
    do_reset();
    cyc(0, 16'h0, 0, 1, 3'd1, 16'd5, 1);
    cyc(0, 16'h0, 0, 1, 3'd2, 16'd7, 1);
    cyc(1, word(5'b00001, 3'd1, 3'd2, 3'd3), 0, 0, 3'd0, 16'h0, 1);
    idle(2, 1);
    cyc(1, word(5'b01000, 3'd4, 3'd1, 3'd5), 0, 1, 3'd4, 16'h00AA, 1);
    cyc(1, 16'h1234, 0, 0, 3'd0, 16'h0, 1);
    idle(2, 1);
    cyc(1, word(5'b10001, 3'd1, 3'd0, 3'd2), 0, 0, 3'd0, 16'h0, 1);
    cyc(1, 16'h0040, 0, 0, 3'd0, 16'h0, 1);
    for (int i = 0; i < 3; i++) cyc(1, word(5'b00010, 3'd2, 3'd1, 3'd6), 0, 0, 3'd0, 16'h0, 1);
    idle(2, 1);
    cyc(1, word(5'b00011, 3'd1, 3'd2, 3'd7), 0, 0, 3'd0, 16'h0, 1);
    for (int i = 0; i < 3; i++) cyc(1, word(5'b00100, 3'd2, 3'd4, 3'd1), 0, 0, 3'd0, 16'h0, 0);
    for (int i = 0; i < 3; i++) cyc(1, word(5'b00100, 3'd2, 3'd4, 3'd1), 0, 0, 3'd0, 16'h0, 1);
    idle(2, 1);
    cyc(1, word(5'b11000, 3'd1, 3'd2, 3'd0), 0, 0, 3'd0, 16'h0, 1);
    cyc(0, 16'h0, 1, 1, 3'd3, 16'h0BEE, 1);
    cyc(1, word(5'b00000, 3'd3, 3'd1, 3'd2), 0, 0, 3'd0, 16'h0, 1);
    cyc(1, word(5'b00001, 3'd3, 3'd4, 3'd5), 0, 0, 3'd0, 16'h0, 1);
    idle(2, 1);
    cyc(1, word(5'b01111, 3'd1, 3'd2, 3'd3), 0, 0, 3'd0, 16'h0, 1);
    do_reset();
    cyc(1, word(5'b00001, 3'd1, 3'd2, 3'd3), 0, 0, 3'd0, 16'h0, 1);
    idle(2, 1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(3, 1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
